// File: rtl/fast_pkg.sv
// Shared constants for the FAST circle sampler: pixel widths, window geometry,
// the radius-3 Bresenham circle offsets and the centre negation helper.
package fast_pkg;

  localparam int PIX_W  = 8;
  localparam int SPIX_W = 9;
  localparam int WIN    = 7;
  localparam int RADIUS = 3;
  localparam int NPTS   = 16;

  // (row, col) of circle points 1..16 inside the 7x7 window, row 0 oldest, col 6 newest
  localparam int CIRC_ROW [NPTS] = '{0, 0, 1, 2, 3, 4, 5, 6, 6, 6, 5, 4, 3, 2, 1, 0};
  localparam int CIRC_COL [NPTS] = '{3, 4, 5, 6, 6, 6, 5, 4, 3, 2, 1, 0, 0, 0, 1, 2};

  function automatic logic [SPIX_W-1:0] neg_pix(input logic [PIX_W-1:0] p);
    return (~{1'b0, p}) + SPIX_W'(1);
  endfunction

endpackage

// File: rtl/fast_line_buffer.sv
// One row of pixel storage with asynchronous read, so a same-cycle write
// behaves read-first and the old row value can cascade into the next buffer.
module fast_line_buffer
  import fast_pkg::*;
#(
  parameter int IMG_WIDTH = 640,
  parameter int COL_W     = 10
) (
  input  logic             clk,
  input  logic [COL_W-1:0] addr,
  input  logic             we,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  logic [PIX_W-1:0] mem [IMG_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

  assign dout = mem[addr];

endmodule

// File: rtl/fast_circle_sampler.sv
// Buffers six lines and a 7x7 window of a grey raster stream and presents the
// 16 radius-3 circle pixels plus the pre-negated centre for the FAST stage.
module fast_circle_sampler
  import fast_pkg::*;
#(
  parameter int IMG_WIDTH = 640,
  parameter int COL_W     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              TVALID_in,
  input  logic              in_H_SYNC,
  input  logic              in_V_SYNC,
  input  logic              in_data_en,
  input  logic [PIX_W-1:0]  in_pixel,
  output logic              o_H_SYNC,
  output logic              o_V_SYNC,
  output logic              o_data_en,
  output logic              o_border,
  output logic [SPIX_W-1:0] signed_point1,
  output logic [SPIX_W-1:0] signed_point2,
  output logic [SPIX_W-1:0] signed_point3,
  output logic [SPIX_W-1:0] signed_point4,
  output logic [SPIX_W-1:0] signed_point5,
  output logic [SPIX_W-1:0] signed_point6,
  output logic [SPIX_W-1:0] signed_point7,
  output logic [SPIX_W-1:0] signed_point8,
  output logic [SPIX_W-1:0] signed_point9,
  output logic [SPIX_W-1:0] signed_point10,
  output logic [SPIX_W-1:0] signed_point11,
  output logic [SPIX_W-1:0] signed_point12,
  output logic [SPIX_W-1:0] signed_point13,
  output logic [SPIX_W-1:0] signed_point14,
  output logic [SPIX_W-1:0] signed_point15,
  output logic [SPIX_W-1:0] signed_point16,
  output logic [SPIX_W-1:0] signed_center
);

  localparam int LAT = 3;

  logic             advance, accept, eol, vs_rise;
  logic [COL_W-1:0] col_cnt, row_cnt;
  logic             in_line, vs_prev;

  assign advance = TVALID_in;
  assign accept  = TVALID_in & in_data_en;
  assign eol     = advance & ~in_data_en & in_line;
  assign vs_rise = advance & in_V_SYNC & ~vs_prev;

  // Frame sync outranks end of line so a coincident edge leaves both counters at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
      in_line <= 1'b0;
      vs_prev <= 1'b0;
    end else if (advance) begin
      vs_prev <= in_V_SYNC;
      if (vs_rise) begin
        col_cnt <= '0;
        row_cnt <= '0;
        in_line <= 1'b0;
      end else if (eol) begin
        col_cnt <= '0;
        if (row_cnt != '1) row_cnt <= row_cnt + 1'b1;
        in_line <= 1'b0;
      end else if (accept) begin
        in_line <= 1'b1;
        if (col_cnt != COL_W'(IMG_WIDTH - 1)) col_cnt <= col_cnt + 1'b1;
      end
    end
  end

  // col_vec[0] is the live pixel, col_vec[k+1] the same column k+1 lines earlier
  logic [PIX_W-1:0] col_vec [WIN];
  assign col_vec[0] = in_pixel;

  for (genvar k = 0; k < WIN - 1; k++) begin : g_lb
    fast_line_buffer #(
      .IMG_WIDTH(IMG_WIDTH),
      .COL_W    (COL_W)
    ) u_lb (
      .clk (clk),
      .addr(col_cnt),
      .we  (accept),
      .din (col_vec[k]),
      .dout(col_vec[k+1])
    );
  end

  logic [PIX_W-1:0] s1_vec [WIN];
  logic [COL_W-1:0] s1_col, s1_row, s2_col, s2_row;
  logic [PIX_W-1:0] win [WIN][WIN];
  logic             border_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_col <= '0;
      s1_row <= '0;
      s2_col <= '0;
      s2_row <= '0;
      for (int i = 0; i < WIN; i++) begin
        s1_vec[i] <= '0;
        for (int j = 0; j < WIN; j++) win[i][j] <= '0;
      end
    end else if (accept) begin
      s1_vec <= col_vec;
      s1_col <= col_cnt;
      s1_row <= row_cnt;
      s2_col <= s1_col;
      s2_row <= s1_row;
      for (int r = 0; r < WIN; r++) begin
        for (int c = 0; c < WIN - 1; c++) win[r][c] <= win[r][c+1];
        win[r][WIN-1] <= s1_vec[WIN-1-r];
      end
    end
  end

  assign border_s2 = (s2_col < COL_W'(WIN - 1)) | (s2_row < COL_W'(WIN - 1));

  logic [SPIX_W-1:0] pts [NPTS];

  // Recomputed on every advance, so blanking simply re-presents the frozen window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_border      <= 1'b0;
      signed_center <= '0;
      for (int k = 0; k < NPTS; k++) pts[k] <= '0;
    end else if (advance) begin
      o_border      <= border_s2;
      signed_center <= neg_pix(win[RADIUS][RADIUS]);
      for (int k = 0; k < NPTS; k++) pts[k] <= {1'b0, win[CIRC_ROW[k]][CIRC_COL[k]]};
    end
  end

  logic [LAT-1:0] hs_sr, vs_sr, de_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_sr <= '0;
      vs_sr <= '0;
      de_sr <= '0;
    end else if (advance) begin
      hs_sr <= {hs_sr[LAT-2:0], in_H_SYNC};
      vs_sr <= {vs_sr[LAT-2:0], in_V_SYNC};
      de_sr <= {de_sr[LAT-2:0], in_data_en};
    end
  end

  assign o_H_SYNC  = hs_sr[LAT-1];
  assign o_V_SYNC  = vs_sr[LAT-1];
  assign o_data_en = de_sr[LAT-1];

  assign signed_point1  = pts[0];
  assign signed_point2  = pts[1];
  assign signed_point3  = pts[2];
  assign signed_point4  = pts[3];
  assign signed_point5  = pts[4];
  assign signed_point6  = pts[5];
  assign signed_point7  = pts[6];
  assign signed_point8  = pts[7];
  assign signed_point9  = pts[8];
  assign signed_point10 = pts[9];
  assign signed_point11 = pts[10];
  assign signed_point12 = pts[11];
  assign signed_point13 = pts[12];
  assign signed_point14 = pts[13];
  assign signed_point15 = pts[14];
  assign signed_point16 = pts[15];

endmodule

// File: tb/tb_fast_circle_sampler.sv
// Bench for fast_circle_sampler: a frame-level image model predicts every output
// each cycle, and literal values pin constant, gradient, extreme and sync cases.
module tb_fast_circle_sampler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       TVALID_in = 1'b0, in_H_SYNC = 1'b0, in_V_SYNC = 1'b0, in_data_en = 1'b0;
  logic [7:0] in_pixel = 8'd0;
  logic       o_H_SYNC, o_V_SYNC, o_data_en, o_border;
  logic [8:0] signed_point1, signed_point2, signed_point3, signed_point4;
  logic [8:0] signed_point5, signed_point6, signed_point7, signed_point8;
  logic [8:0] signed_point9, signed_point10, signed_point11, signed_point12;
  logic [8:0] signed_point13, signed_point14, signed_point15, signed_point16;
  logic [8:0] signed_center;
  logic [8:0] act_pt [16];

  fast_circle_sampler dut (
    .clk(clk), .rst_n(rst_n), .TVALID_in(TVALID_in),
    .in_H_SYNC(in_H_SYNC), .in_V_SYNC(in_V_SYNC), .in_data_en(in_data_en), .in_pixel(in_pixel),
    .o_H_SYNC(o_H_SYNC), .o_V_SYNC(o_V_SYNC), .o_data_en(o_data_en), .o_border(o_border),
    .signed_point1(signed_point1), .signed_point2(signed_point2),
    .signed_point3(signed_point3), .signed_point4(signed_point4),
    .signed_point5(signed_point5), .signed_point6(signed_point6),
    .signed_point7(signed_point7), .signed_point8(signed_point8),
    .signed_point9(signed_point9), .signed_point10(signed_point10),
    .signed_point11(signed_point11), .signed_point12(signed_point12),
    .signed_point13(signed_point13), .signed_point14(signed_point14),
    .signed_point15(signed_point15), .signed_point16(signed_point16),
    .signed_center(signed_center)
  );

  assign act_pt[0]  = signed_point1;  assign act_pt[1]  = signed_point2;
  assign act_pt[2]  = signed_point3;  assign act_pt[3]  = signed_point4;
  assign act_pt[4]  = signed_point5;  assign act_pt[5]  = signed_point6;
  assign act_pt[6]  = signed_point7;  assign act_pt[7]  = signed_point8;
  assign act_pt[8]  = signed_point9;  assign act_pt[9]  = signed_point10;
  assign act_pt[10] = signed_point11; assign act_pt[11] = signed_point12;
  assign act_pt[12] = signed_point13; assign act_pt[13] = signed_point14;
  assign act_pt[14] = signed_point15; assign act_pt[15] = signed_point16;

  always #5 clk = ~clk;

  int  tests = 0;
  int  fails = 0;
  bit  check_en = 1'b0;
  bit  toggle_mode = 1'b0;
  int  cur_mode = -1;
  bit  hit [4];

  // Circle point k as (row, col) offsets from the window's top-left pixel
  int cr [16] = '{0, 0, 1, 2, 3, 4, 5, 6, 6, 6, 5, 4, 3, 2, 1, 0};
  int cc [16] = '{3, 4, 5, 6, 6, 6, 5, 4, 3, 2, 1, 0, 0, 0, 1, 2};

  task automatic checkOutput(input string name, input logic [8:0] act, input logic [8:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: image as accepted, line/column position, last two accept positions
  int   img [64][32];
  int   m_row, m_col, acc_n, last_r, last_c, prev_r, prev_c, v;
  bit   m_inline, m_vs_prev, vs_rise;
  bit   hq[$], vq[$], dq[$];
  bit   e_hs, e_vs, e_de, e_border;
  logic [8:0] e_pt [16];
  logic [8:0] e_ctr;
  int   e_nr, e_nc;

  // Each advance presents the window whose newest column is the second-latest accept
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_row = 0; m_col = 0; m_inline = 0; m_vs_prev = 0; acc_n = 0;
      last_r = 0; last_c = 0; prev_r = 0; prev_c = 0;
      hq.delete(); vq.delete(); dq.delete();
      e_hs = 0; e_vs = 0; e_de = 0; e_border = 0; e_ctr = '0; e_nr = -1; e_nc = -1;
      for (int k = 0; k < 16; k++) e_pt[k] = '0;
    end else if (TVALID_in) begin
      if (acc_n < 2) begin
        e_border = 1; e_nr = -1; e_nc = -1;
      end else begin
        e_nr = prev_r; e_nc = prev_c;
        e_border = (prev_r < 6) || (prev_c < 6);
        if (!e_border) begin
          for (int k = 0; k < 16; k++) e_pt[k] = 9'(img[prev_r-6+cr[k]][prev_c-6+cc[k]]);
          v = img[prev_r-3][prev_c-3];
          e_ctr = 9'((512 - v) % 512);
        end
      end
      hq.push_back(in_H_SYNC); vq.push_back(in_V_SYNC); dq.push_back(in_data_en);
      if (hq.size() > 3) begin hq.delete(0); vq.delete(0); dq.delete(0); end
      e_hs = (hq.size() == 3) ? hq[0] : 1'b0;
      e_vs = (vq.size() == 3) ? vq[0] : 1'b0;
      e_de = (dq.size() == 3) ? dq[0] : 1'b0;
      vs_rise = in_V_SYNC && !m_vs_prev;
      m_vs_prev = in_V_SYNC;
      if (in_data_en) begin
        if (m_row < 64 && m_col < 32) img[m_row][m_col] = int'(in_pixel);
        prev_r = last_r; prev_c = last_c; last_r = m_row; last_c = m_col;
        acc_n++;
      end
      if (vs_rise) begin
        m_row = 0; m_col = 0; m_inline = 0;
      end else if (!in_data_en && m_inline) begin
        m_row++; m_col = 0; m_inline = 0;
      end else if (in_data_en) begin
        m_inline = 1; m_col++;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("o_H_SYNC", {8'd0, o_H_SYNC}, {8'd0, e_hs});
      checkOutput("o_V_SYNC", {8'd0, o_V_SYNC}, {8'd0, e_vs});
      checkOutput("o_data_en", {8'd0, o_data_en}, {8'd0, e_de});
      checkOutput("o_border", {8'd0, o_border}, {8'd0, e_border});
      if (!e_border) begin
        for (int k = 0; k < 16; k++) checkOutput($sformatf("pt%0d", k + 1), act_pt[k], e_pt[k]);
        checkOutput("center", signed_center, e_ctr);
        if (cur_mode == 0 && e_nr >= 0) begin
          hit[0] = 1;
          for (int k = 0; k < 16; k++) checkOutput($sformatf("const_pt%0d", k + 1), act_pt[k], 9'h064);
          checkOutput("const_center", signed_center, 9'h19C);
        end
        if (e_nr == 8 && e_nc == 10) begin
          if (cur_mode == 1) begin
            hit[1] = 1;
            checkOutput("grad_center", signed_center, 9'h1A9);
            checkOutput("grad_pt1", signed_point1, 9'd39);
            checkOutput("grad_pt5", signed_point5, 9'd90);
            checkOutput("grad_pt9", signed_point9, 9'd135);
            checkOutput("grad_pt13", signed_point13, 9'd84);
          end else if (cur_mode == 2) begin
            hit[2] = 1;
            checkOutput("ext255_center", signed_center, 9'h101);
            for (int k = 0; k < 16; k++) checkOutput($sformatf("ext255_pt%0d", k + 1), act_pt[k], 9'h000);
          end else if (cur_mode == 3) begin
            hit[3] = 1;
            checkOutput("ext0_center", signed_center, 9'h000);
            for (int k = 0; k < 16; k++) checkOutput($sformatf("ext0_pt%0d", k + 1), act_pt[k], 9'h0FF);
          end
        end
      end
    end
  end

  task automatic applyStimulus(input bit tv, input bit vs, input bit hs, input bit de, input logic [7:0] pix);
    TVALID_in = tv; in_V_SYNC = vs; in_H_SYNC = hs; in_data_en = de; in_pixel = pix;
    @(posedge clk); #1;
  endtask

  task automatic stallCycle();
    applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 8'($urandom));
  endtask

  task automatic adv(input bit vs, input bit hs, input bit de, input logic [7:0] pix);
    if (toggle_mode) stallCycle();
    applyStimulus(1'b1, vs, hs, de, pix);
  endtask

  function automatic logic [7:0] pix_of(input int mode, input int r, input int c);
    case (mode)
      0:       return 8'd100;
      1:       return 8'(r * 16 + c);
      2:       return (r == 5 && c == 7) ? 8'd255 : 8'd0;
      3:       return (r == 5 && c == 7) ? 8'd0 : 8'd255;
      default: return 8'((r * 7 + c * 13) % 256);
    endcase
  endfunction

  task automatic doReset();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_border", {8'd0, o_border}, 9'd0);
    checkOutput("rst_hs", {8'd0, o_H_SYNC}, 9'd0);
    checkOutput("rst_vs", {8'd0, o_V_SYNC}, 9'd0);
    checkOutput("rst_de", {8'd0, o_data_en}, 9'd0);
    checkOutput("rst_center", signed_center, 9'd0);
    for (int k = 0; k < 16; k++) checkOutput($sformatf("rst_pt%0d", k + 1), act_pt[k], 9'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // 16-wide frame: 2 V_SYNC cycles, then per line an H_SYNC, 2 blank, 16 pixels, 3 blank
  task automatic runFrame(input int mode, input int height, input int stall_row, input int reset_row);
    bit abandon;
    cur_mode = mode;
    adv(1, 0, 0, 0); adv(1, 0, 0, 0); adv(0, 0, 0, 0); adv(0, 0, 0, 0);
    for (int r = 0; r < height; r++) begin
      abandon = 0;
      adv(0, 1, 0, 0); adv(0, 0, 0, 0); adv(0, 0, 0, 0);
      for (int c = 0; c < 16; c++) begin
        if (r == stall_row && c == 8) repeat (5) stallCycle();
        if (r == reset_row && c == 8) begin
          doReset();
          abandon = 1;
        end
        if (abandon) adv(0, 0, 0, 0);
        else         adv(0, 0, 1, pix_of(mode, r, c));
      end
      adv(0, 0, 0, 0); adv(0, 0, 0, 0); adv(0, 0, 0, 0);
    end
  endtask

  initial begin
    int exp_a [4];
    int exp_t [7];
    exp_a = '{0, 0, 1, 0};
    exp_t = '{0, 0, 0, 0, 1, 1, 0};
    repeat (2) @(posedge clk);
    #1;
    check_en = 1'b1;
    checkOutput("reset_border", {8'd0, o_border}, 9'd0);
    checkOutput("reset_center", signed_center, 9'd0);
    rst_n = 1'b1;

    applyStimulus(1, 0, 1, 0, 0);
    checkOutput("hs_lat0", {8'd0, o_H_SYNC}, 9'(exp_a[0]));
    for (int i = 1; i < 4; i++) begin
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput($sformatf("hs_lat%0d", i), {8'd0, o_H_SYNC}, 9'(exp_a[i]));
    end
    repeat (3) applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'(i % 2 == 0), 0, 1'(i == 0), 0, 0);
      checkOutput($sformatf("hs_tog%0d", i), {8'd0, o_H_SYNC}, 9'(exp_t[i]));
    end

    runFrame(0, 10, -1, -1);
    runFrame(1, 10, 7, -1);
    runFrame(2, 10, -1, -1);
    toggle_mode = 1'b1;
    runFrame(3, 10, -1, -1);
    toggle_mode = 1'b0;
    runFrame(4, 14, -1, 2);
    repeat (4) adv(0, 0, 0, 0);

    for (int m = 0; m < 4; m++) checkOutput($sformatf("literal_reached_mode%0d", m), {8'd0, hit[m]}, 9'd1);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected end of stimulus");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
